apb_master_arbiter: RTL and testbench

Shares one APB master port between `NREQ` requesters that use the team's `newd`-style request interface (slave select, 4-bit address, 8-bit data, read/write). The arbiter is round-robin and sequences each granted request through the APB SETUP and ACCESS phases. It returns read data and error status to the winner. It sits between the requesting front-ends and the `one_slave` / multi-slave APB fabric.

---
 rtl/apb_arb_pkg.sv | 23 ++
 rtl/apb_master_arbiter_rr.sv | 32 +++
 rtl/apb_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB master arbiter.
package apb_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int SLV_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        COMPLETE
    } arb_state_t;

    // One requester's transaction as latched at grant time.
    typedef struct packed {
        logic              wr;
        logic [SLV_W-1:0]  slv;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker: the requester just after i_last wins.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 2) ? 2 : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_dist;
    int w_best;

    // Each requester's distance past i_last is its priority; the smallest pending distance wins.
    always_comb begin
        w_dist = 0;
        w_best = NREQ;
        o_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(i_last)) % NREQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_W'(i);
            end
        end
        o_any = |i_req;
        o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          req_wr_i,
    input  logic [NREQ*SLV_W-1:0]    req_slv_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     err_o,
    output logic [NSLV-1:0]          psel_o,
    output logic                     penable_o,
    output logic                     pwrite_o,
    output logic [ADDR_W-1:0]        paddr_o,
    output logic [DATA_W-1:0]        pwdata_o,
    input  logic                     pready_i,
    input  logic                     pslverr_i,
    input  logic [DATA_W-1:0]        prdata_i
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    apb_req_t          r_req;
    apb_req_t          w_winReq;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_winGnt;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  w_winIdx;
    logic              w_anyReq;
    logic              w_decErr;
    logic              w_timeout;
    logic [CNT_W-1:0]  r_waitCnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [NSLV-1:0]   w_pselDec;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req  (req_i),
        .i_last (r_last),
        .o_gnt  (w_winGnt),
        .o_idx  (w_winIdx),
        .o_any  (w_anyReq)
    );

    // Gather the winning requester's fields into one record for latching.
    always_comb begin
        w_winReq = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winIdx == IDX_W'(i)) begin
                w_winReq.wr    = req_wr_i[i];
                w_winReq.slv   = req_slv_i[i*SLV_W +: SLV_W];
                w_winReq.addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                w_winReq.wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_decErr  = (int'(w_winReq.slv) >= NSLV);
    assign w_timeout = (r_waitCnt == CNT_LAST);
    assign w_pselDec = NSLV'(1) << r_req.slv;

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; undecodable slaves skip the bus cycle entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_anyReq) w_nextState = w_decErr ? COMPLETE : SETUP;
            SETUP:    w_nextState = ACCESS;
            ACCESS:   if (pready_i || w_timeout) w_nextState = COMPLETE;
            COMPLETE: w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // Bus strobes and the completion pulse decoded from the current state.
    always_comb begin
        psel_o    = '0;
        penable_o = 1'b0;
        done_o    = '0;
        case (r_state)
            SETUP:    psel_o = w_pselDec;
            ACCESS: begin
                psel_o    = w_pselDec;
                penable_o = 1'b1;
            end
            COMPLETE: done_o = r_gnt;
            default: ;
        endcase
    end

    // Grant, latched request, wait counter and result registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_req     <= '0;
            r_gnt     <= '0;
            r_last    <= IDX_W'(NREQ - 1);
            r_waitCnt <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_req     <= w_winReq;
                        r_gnt     <= w_winGnt;
                        r_last    <= w_winIdx;
                        r_waitCnt <= '0;
                        if (w_decErr) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                SETUP: r_waitCnt <= '0;
                ACCESS: begin
                    if (r_waitCnt != CNT_MAX) r_waitCnt <= r_waitCnt + 1'b1;
                    if (pready_i) begin
                        r_rdata <= r_req.wr ? '0 : prdata_i;
                        r_err   <= pslverr_i;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                COMPLETE: r_gnt <= '0;
                default: ;
            endcase
        end
    end

    assign gnt_o    = r_gnt;
    assign paddr_o  = r_req.addr;
    assign pwdata_o = r_req.wdata;
    assign pwrite_o = r_req.wr;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a per-cycle vector table plus
// hand-written wait-state, timeout and mid-transaction reset sequences.
module tb_apb_master_arbiter;

    logic       pclk = 1'b0;
    logic       preset;
    logic [1:0] req_i, req_wr_i;
    logic [3:0] req_slv_i;
    logic [7:0] req_addr_i;
    logic [15:0] req_wdata_i;
    logic [1:0] gnt_o, done_o;
    logic [7:0] rdata_o;
    logic       err_o;
    logic [2:0] psel_o;
    logic       penable_o, pwrite_o;
    logic [3:0] paddr_o;
    logic [7:0] pwdata_o;
    logic       pready_i, pslverr_i;
    logic [7:0] prdata_i;

    int checks = 0;
    int errors = 0;

    apb_master_arbiter #(.NREQ(2), .NSLV(3), .TIMEOUT(15)) dut (
        .pclk(pclk), .preset(preset),
        .req_i(req_i), .req_wr_i(req_wr_i), .req_slv_i(req_slv_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
    );

    always #5 pclk = ~pclk;

    // Inputs held for one clock edge and the outputs expected just after it.
    typedef struct {
        logic rst; logic [1:0] req, wr; logic [3:0] slv; logic [7:0] addr;
        logic [15:0] wdata; logic rdy, serr; logic [7:0] prd;
        logic [1:0] gnt, done; logic [2:0] psel; logic pen, pwr;
        logic [3:0] paddr; logic [7:0] pwd, rdata; logic err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] req, input logic [1:0] wr,
        input logic [3:0] slv, input logic [7:0] addr, input logic [15:0] wdata,
        input logic rdy, input logic serr, input logic [7:0] prd,
        input logic [1:0] gnt, input logic [1:0] done, input logic [2:0] psel,
        input logic pen, input logic pwr, input logic [3:0] paddr,
        input logic [7:0] pwd, input logic [7:0] rdata, input logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.wr = wr; v.slv = slv; v.addr = addr;
        v.wdata = wdata; v.rdy = rdy; v.serr = serr; v.prd = prd;
        v.gnt = gnt; v.done = done; v.psel = psel; v.pen = pen; v.pwr = pwr;
        v.paddr = paddr; v.pwd = pwd; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        preset = v.rst; req_i = v.req; req_wr_i = v.wr; req_slv_i = v.slv;
        req_addr_i = v.addr; req_wdata_i = v.wdata; pready_i = v.rdy;
        pslverr_i = v.serr; prdata_i = v.prd;
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRow(input string tag, input vec_t v);
        checkOutput({tag, " gnt"},     16'(gnt_o),     16'(v.gnt));
        checkOutput({tag, " done"},    16'(done_o),    16'(v.done));
        checkOutput({tag, " psel"},    16'(psel_o),    16'(v.psel));
        checkOutput({tag, " penable"}, 16'(penable_o), 16'(v.pen));
        checkOutput({tag, " pwrite"},  16'(pwrite_o),  16'(v.pwr));
        checkOutput({tag, " paddr"},   16'(paddr_o),   16'(v.paddr));
        checkOutput({tag, " pwdata"},  16'(pwdata_o),  16'(v.pwd));
        checkOutput({tag, " rdata"},   16'(rdata_o),   16'(v.rdata));
        checkOutput({tag, " err"},     16'(err_o),     16'(v.err));
    endtask

    task automatic runStep(input string tag, input vec_t v);
        applyStimulus(v);
        checkRow(tag, v);
    endtask

    initial begin
        // rst req wr slv addr wdata rdy serr prd | gnt done psel pen pwr paddr pwd rdata err
        // Reset, then a zero-wait write from requester 0 to slave 1.
        vecs.push_back(mk(1, 2'b00, 2'b00, 4'h0, 8'h00, 16'h0000, 0, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 0, 4'h0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 4'h1, 8'h03, 16'h000F, 1, 0, 8'h77, 2'b01, 2'b00, 3'b010, 0, 1, 4'h3, 8'h0F, 8'h00, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 4'h1, 8'h03, 16'h000F, 1, 0, 8'h77, 2'b01, 2'b00, 3'b010, 1, 1, 4'h3, 8'h0F, 8'h00, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 4'h1, 8'h03, 16'h000F, 1, 0, 8'h77, 2'b01, 2'b01, 3'b000, 0, 1, 4'h3, 8'h0F, 8'h00, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 4'h1, 8'h03, 16'h000F, 1, 0, 8'h77, 2'b00, 2'b00, 3'b000, 0, 1, 4'h3, 8'h0F, 8'h00, 0));
        // Reset again, then simultaneous reads: requester 0 first, requester 1 next.
        vecs.push_back(mk(1, 2'b00, 2'b00, 4'h0, 8'h00, 16'h0000, 0, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 0, 4'h0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'hA5, 2'b01, 2'b00, 3'b001, 0, 0, 4'h2, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'hA5, 2'b01, 2'b00, 3'b001, 1, 0, 4'h2, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'hA5, 2'b01, 2'b01, 3'b000, 0, 0, 4'h2, 8'h00, 8'hA5, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'hA5, 2'b00, 2'b00, 3'b000, 0, 0, 4'h2, 8'h00, 8'hA5, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'hA5, 2'b10, 2'b00, 3'b100, 0, 0, 4'h6, 8'h00, 8'hA5, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'hA5, 2'b10, 2'b00, 3'b100, 1, 0, 4'h6, 8'h00, 8'hA5, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'h3C, 2'b10, 2'b10, 3'b000, 0, 0, 4'h6, 8'h00, 8'h3C, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 4'h8, 8'h62, 16'h0000, 1, 0, 8'h3C, 2'b00, 2'b00, 3'b000, 0, 0, 4'h6, 8'h00, 8'h3C, 0));
        // Slave index 3 is undecodable: straight to COMPLETE with an error.
        vecs.push_back(mk(0, 2'b01, 2'b00, 4'h3, 8'h09, 16'h0000, 1, 0, 8'h00, 2'b01, 2'b01, 3'b000, 0, 0, 4'h9, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 4'h3, 8'h09, 16'h0000, 1, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 0, 4'h9, 8'h00, 8'h00, 1));
        // Simultaneous writes after requester 0 was last: requester 1 first.
        vecs.push_back(mk(0, 2'b11, 2'b11, 4'h4, 8'hBA, 16'h2211, 1, 0, 8'h00, 2'b10, 2'b00, 3'b010, 0, 1, 4'hB, 8'h22, 8'h00, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 4'h4, 8'hBA, 16'h2211, 1, 0, 8'h00, 2'b10, 2'b00, 3'b010, 1, 1, 4'hB, 8'h22, 8'h00, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 4'h4, 8'hBA, 16'h2211, 1, 0, 8'h00, 2'b10, 2'b10, 3'b000, 0, 1, 4'hB, 8'h22, 8'h00, 0));
        vecs.push_back(mk(0, 2'b01, 2'b11, 4'h4, 8'hBA, 16'h2211, 1, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 1, 4'hB, 8'h22, 8'h00, 0));
        vecs.push_back(mk(0, 2'b01, 2'b11, 4'h4, 8'hBA, 16'h2211, 1, 0, 8'h00, 2'b01, 2'b00, 3'b001, 0, 1, 4'hA, 8'h11, 8'h00, 0));
        // Fields change after the latch and must be ignored; slave error on the write.
        vecs.push_back(mk(0, 2'b01, 2'b11, 4'h4, 8'hBF, 16'h22EE, 1, 0, 8'h00, 2'b01, 2'b00, 3'b001, 1, 1, 4'hA, 8'h11, 8'h00, 0));
        vecs.push_back(mk(0, 2'b01, 2'b11, 4'h4, 8'hBF, 16'h22EE, 1, 1, 8'h00, 2'b01, 2'b01, 3'b000, 0, 1, 4'hA, 8'h11, 8'h00, 1));
        vecs.push_back(mk(0, 2'b00, 2'b11, 4'h4, 8'hBF, 16'h22EE, 1, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 1, 4'hA, 8'h11, 8'h00, 1));

        @(posedge pclk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            runStep($sformatf("row%0d", i), vecs[i]);
        end

        // Read with three wait states: done at the sixth cycle after the request.
        for (int n = 1; n <= 6; n++) begin
            runStep($sformatf("wait%0d", n), mk(0, 2'b01, 2'b00, 4'h1, 8'h05, 16'h0000, (n == 6), 0, 8'h19,
                2'b01, (n == 6) ? 2'b01 : 2'b00, (n <= 5) ? 3'b010 : 3'b000, (n >= 2 && n <= 5), 0,
                4'h5, 8'h00, (n == 6) ? 8'h19 : 8'h00, (n != 6)));
        end
        runStep("waitIdle", mk(0, 2'b00, 2'b00, 4'h1, 8'h05, 16'h0000, 0, 0, 8'h19,
            2'b00, 2'b00, 3'b000, 0, 0, 4'h5, 8'h00, 8'h19, 0));

        // pready stuck low: abort after fifteen ACCESS cycles.
        for (int n = 1; n <= 17; n++) begin
            runStep($sformatf("tmo%0d", n), mk(0, 2'b10, 2'b00, 4'h8, 8'h70, 16'h0000, 0, 0, 8'hEE,
                2'b10, (n == 17) ? 2'b10 : 2'b00, (n <= 16) ? 3'b100 : 3'b000, (n >= 2 && n <= 16), 0,
                4'h7, 8'h00, (n == 17) ? 8'h00 : 8'h19, (n == 17)));
        end
        runStep("tmoIdle", mk(0, 2'b00, 2'b00, 4'h8, 8'h70, 16'h0000, 0, 0, 8'hEE, 2'b00, 2'b00, 3'b000, 0, 0, 4'h7, 8'h00, 8'h00, 1));
        runStep("post1",   mk(0, 2'b01, 2'b01, 4'h0, 8'h0C, 16'h0044, 1, 0, 8'h00, 2'b01, 2'b00, 3'b001, 0, 1, 4'hC, 8'h44, 8'h00, 1));
        runStep("post2",   mk(0, 2'b01, 2'b01, 4'h0, 8'h0C, 16'h0044, 1, 0, 8'h00, 2'b01, 2'b00, 3'b001, 1, 1, 4'hC, 8'h44, 8'h00, 1));
        runStep("post3",   mk(0, 2'b01, 2'b01, 4'h0, 8'h0C, 16'h0044, 1, 0, 8'h00, 2'b01, 2'b01, 3'b000, 0, 1, 4'hC, 8'h44, 8'h00, 0));
        runStep("post4",   mk(0, 2'b00, 2'b01, 4'h0, 8'h0C, 16'h0044, 1, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 1, 4'hC, 8'h44, 8'h00, 0));

        // Reset during ACCESS drops the transfer; requester 0 is granted again afterwards.
        runStep("rst1",  mk(0, 2'b01, 2'b00, 4'h1, 8'h08, 16'h0000, 0, 0, 8'h00, 2'b01, 2'b00, 3'b010, 0, 0, 4'h8, 8'h00, 8'h00, 0));
        runStep("rst2",  mk(0, 2'b11, 2'b00, 4'h9, 8'h38, 16'h0000, 0, 0, 8'h00, 2'b01, 2'b00, 3'b010, 1, 0, 4'h8, 8'h00, 8'h00, 0));
        runStep("rst3",  mk(0, 2'b11, 2'b00, 4'h9, 8'h38, 16'h0000, 0, 0, 8'h00, 2'b01, 2'b00, 3'b010, 1, 0, 4'h8, 8'h00, 8'h00, 0));
        runStep("rstOn", mk(1, 2'b11, 2'b00, 4'h9, 8'h38, 16'h0000, 0, 0, 8'h00, 2'b00, 2'b00, 3'b000, 0, 0, 4'h0, 8'h00, 8'h00, 0));
        runStep("rel1",  mk(0, 2'b11, 2'b00, 4'h9, 8'h38, 16'h0000, 1, 0, 8'h42, 2'b01, 2'b00, 3'b010, 0, 0, 4'h8, 8'h00, 8'h00, 0));
        runStep("rel2",  mk(0, 2'b11, 2'b00, 4'h9, 8'h38, 16'h0000, 1, 0, 8'h42, 2'b01, 2'b00, 3'b010, 1, 0, 4'h8, 8'h00, 8'h00, 0));
        runStep("rel3",  mk(0, 2'b11, 2'b00, 4'h9, 8'h38, 16'h0000, 1, 0, 8'h42, 2'b01, 2'b01, 3'b000, 0, 0, 4'h8, 8'h00, 8'h42, 0));
        runStep("rel4",  mk(0, 2'b10, 2'b00, 4'h9, 8'h38, 16'h0000, 1, 0, 8'h42, 2'b00, 2'b00, 3'b000, 0, 0, 4'h8, 8'h00, 8'h42, 0));
        runStep("rel5",  mk(0, 2'b10, 2'b00, 4'h9, 8'h38, 16'h0000, 1, 0, 8'h42, 2'b10, 2'b00, 3'b100, 0, 0, 4'h3, 8'h00, 8'h42, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
